// File: rtl/clkint.sv
// Reset-conditioning global buffer for the 50 MHz domain: merges a stretched
// power-on reset and a synchronised GSE reset into one active-low system reset.
module clkint #(
    parameter int STRETCH_BITS = 26
) (
    input  logic clk50,
    input  logic resetn_in,
    input  logic gse_reset,
    input  logic A,
    output logic Y,
    output logic rst_n,
    output logic por_done
);

    localparam int CW = STRETCH_BITS + 1;

    logic          r_sync1;
    logic          r_sync2;
    logic [CW-1:0] r_cnt;
    logic          w_busy;

    // Two-flop GSE stage: cleared asynchronously, released after two edges.
    always_ff @(posedge clk50 or posedge gse_reset) begin
        if (gse_reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= 1'b1;
            r_sync2 <= r_sync1;
        end
    end

    // POR stretch counter: the top bit is the busy flag; once the low bits
    // wrap, busy clears and the counter holds until the next POR.
    always_ff @(posedge clk50 or negedge resetn_in) begin
        if (!resetn_in) begin
            r_cnt <= {1'b1, {STRETCH_BITS{1'b0}}};
        end else if (w_busy) begin
            r_cnt <= r_cnt + CW'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign w_busy   = r_cnt[STRETCH_BITS];
    assign por_done = ~w_busy;
    assign rst_n    = r_sync2 & por_done;
    assign Y        = A;

endmodule

// File: tb/tb_clkint.sv
// Randomised and directed bench for clkint with an edge-counting reset model.
module tb_clkint;

    localparam int SB   = 4;
    localparam int NPOR = 2 ** SB;

    logic clk50;
    logic resetn_in;
    logic gse_reset;
    logic A;
    logic Y;
    logic rst_n;
    logic por_done;

    clkint #(.STRETCH_BITS(SB)) dut (
        .clk50     (clk50),
        .resetn_in (resetn_in),
        .gse_reset (gse_reset),
        .A         (A),
        .Y         (Y),
        .rst_n     (rst_n),
        .por_done  (por_done)
    );

    initial clk50 = 1'b0;
    always #10 clk50 = ~clk50;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: edges seen since each source released, saturating.
    int por_edges = 0;
    int gse_edges = 0;
    bit model_valid = 1'b0;

    always @(posedge clk50) begin
        if (!resetn_in) por_edges = 0;
        else if (por_edges < NPOR) por_edges = por_edges + 1;
        if (gse_reset) gse_edges = 0;
        else if (gse_edges < 2) gse_edges = gse_edges + 1;
    end

    // Directed expectations handed to the compare process.
    int    probe_cnt = 0;
    int    probe_seen = 0;
    string pin_name;
    bit    pin_up, pin_ur, pin_uc;
    logic  pin_por, pin_rst;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests = n_tests + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Single compare process: model check every falling edge and at probes.
    always @(negedge clk50 or probe_cnt) begin
        logic exp_por;
        logic exp_rst;
        exp_por = resetn_in && (por_edges >= NPOR);
        exp_rst = exp_por && !gse_reset && (gse_edges >= 2);
        chk("buffer_y", 32'(Y), 32'(A));
        if (model_valid) begin
            chk("model_por_done", 32'(por_done), 32'(exp_por));
            chk("model_rst_n", 32'(rst_n), 32'(exp_rst));
        end
        if (probe_cnt != probe_seen) begin
            probe_seen = probe_cnt;
            if (pin_up) chk({pin_name, "_por_done"}, 32'(por_done), 32'(pin_por));
            if (pin_ur) chk({pin_name, "_rst_n"}, 32'(rst_n), 32'(pin_rst));
            if (pin_uc) chk({pin_name, "_cnt"}, 32'(dut.r_cnt), 32'd0);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk50);
        #5;
    endtask

    task automatic pin(input string nm, input bit up, input logic ep,
                       input bit ur, input logic er, input bit uc);
        #1;
        pin_name = nm;
        pin_up = up; pin_por = ep;
        pin_ur = ur; pin_rst = er;
        pin_uc = uc;
        probe_cnt = probe_cnt + 1;
        #1;
    endtask

    task automatic probe();
        #1;
        pin_up = 1'b0; pin_ur = 1'b0; pin_uc = 1'b0;
        probe_cnt = probe_cnt + 1;
        #1;
    endtask

    initial begin
        resetn_in = 1'b1;
        gse_reset = 1'b0;
        A         = 1'b0;

        // POR only
        step(49);
        resetn_in = 1'b0;
        model_valid = 1'b1;
        pin("por_assert", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(100);
        resetn_in = 1'b1;
        step(NPOR - 1);
        pin("por_edge15", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1);
        pin("por_edge16", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        step(20);
        pin("por_hold", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

        // Saturation
        step(100);
        pin("saturate", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

        // GSE release after POR completion
        gse_reset = 1'b1;
        pin("gse_assert", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(5);
        gse_reset = 1'b0;
        pin("gse_rel0", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1);
        pin("gse_rel1", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1);
        pin("gse_rel2", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

        // GSE held across a full POR
        gse_reset = 1'b1;
        resetn_in = 1'b0;
        pin("held_assert", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(100);
        resetn_in = 1'b1;
        step(NPOR - 1);
        pin("held_edge15", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1);
        pin("held_edge16", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(30);
        pin("held_long", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        gse_reset = 1'b0;
        step(2);
        pin("held_release", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

        // Mid-stretch re-assert
        resetn_in = 1'b0;
        step(2);
        resetn_in = 1'b1;
        step(8);
        resetn_in = 1'b0;
        pin("mid_reassert", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1);
        resetn_in = 1'b1;
        step(NPOR - 1);
        pin("mid_edge15", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1);
        pin("mid_edge16", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

        // Randomised resets and buffer toggling
        for (int it = 0; it < 200; it++) begin
            int kind;
            int len;
            kind = int'($urandom_range(0, 3));
            len  = int'($urandom_range(1, 4));
            case (kind)
                0: begin
                    gse_reset = 1'b1; A = 1'($urandom); probe();
                    step(len);
                    gse_reset = 1'b0; probe();
                end
                1: begin
                    resetn_in = 1'b0; A = 1'($urandom); probe();
                    step(len);
                    resetn_in = 1'b1; probe();
                end
                2: begin
                    resetn_in = 1'b0; gse_reset = 1'b1; probe();
                    step(len);
                    resetn_in = 1'b1; gse_reset = 1'b0; probe();
                end
                default: begin
                    #($urandom_range(0, 3));
                    A = 1'($urandom); probe();
                end
            endcase
            for (int k = 0, n = int'($urandom_range(0, 24)); k < n; k++) begin
                step(1);
                A = 1'($urandom);
                probe();
            end
        end

        step(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
